// File: rtl/beta_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the default
// completion timeout.
package beta_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      IRD  = 3'd1,
      DRD  = 3'd2,
      DWR  = 3'd3,
      RESP = 3'd4
   } arb_state_t;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory bus, one
// transaction at a time. Define MEM_ARBITER_RR_EN for round-robin; default is data priority.
module mem_arbiter
   import beta_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          iReq,
   input  logic [AW-1:0] iAddr,
   output logic          iAck,
   output logic [DW-1:0] iRdata,
   input  logic          dReq,
   input  logic          dWe,
   input  logic [AW-1:0] dAddr,
   input  logic [DW-1:0] dWdata,
   output logic          dAck,
   output logic [DW-1:0] dRdata,
   output logic          memRead,
   output logic          memWrite,
   output logic [AW-1:0] memAddr,
   output logic [DW-1:0] memWriteData,
   input  logic          memReadReady,
   input  logic          memWriteDone,
   input  logic [DW-1:0] memReadData,
   output logic          err,
   output arb_state_t    dbgState
);

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

   // Handshake: a requester raises req with stable address/data and holds them
   // until it sees its ack pulse; the arbiter only samples requests in IDLE.
   arb_state_t state;
   logic [7:0] wait_cnt;
   logic       grant_d;
   logic       resp_data;
   logic       timed_out;

`ifdef MEM_ARBITER_RR_EN
   logic last_d;

   // On a tie the port that did not win last time goes first.
   assign grant_d = dReq & (~iReq | ~last_d);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_d <= 1'b0;
      end else if (state == IDLE && (iReq || dReq)) begin
         last_d <= grant_d;
      end
   end
`else
   assign grant_d = dReq;
`endif

   assign dbgState = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         memRead      <= 1'b0;
         memWrite     <= 1'b0;
         memAddr      <= '0;
         memWriteData <= '0;
         iAck         <= 1'b0;
         dAck         <= 1'b0;
         err          <= 1'b0;
         iRdata       <= '0;
         dRdata       <= '0;
         wait_cnt     <= '0;
         resp_data    <= 1'b0;
         timed_out    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (iReq || dReq) begin
                  wait_cnt  <= '0;
                  timed_out <= 1'b0;
                  resp_data <= grant_d;
                  if (grant_d) begin
                     memAddr <= dAddr;
                     if (dWe) begin
                        memWrite     <= 1'b1;
                        memWriteData <= dWdata;
                        state        <= DWR;
                     end else begin
                        memRead <= 1'b1;
                        state   <= DRD;
                     end
                  end else begin
                     memAddr <= iAddr;
                     memRead <= 1'b1;
                     state   <= IRD;
                  end
               end
            end

            IRD, DRD: begin
               if (memReadReady) begin
                  memRead <= 1'b0;
                  if (state == IRD) iRdata <= memReadData;
                  else              dRdata <= memReadData;
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                     memRead   <= 1'b0;
                     timed_out <= 1'b1;
                     state     <= RESP;
                  end
               end
            end

            DWR: begin
               if (memWriteDone) begin
                  memWrite <= 1'b0;
                  state    <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                     memWrite  <= 1'b0;
                     timed_out <= 1'b1;
                     state     <= RESP;
                  end
               end
            end

            // First RESP cycle raises the ack; the second cycle presents it and
            // returns to IDLE, so the requester can drop req before the next grant.
            RESP: begin
               if (!(iAck || dAck)) begin
                  iAck <= ~resp_data;
                  dAck <= resp_data;
                  err  <= timed_out;
               end else begin
                  iAck  <= 1'b0;
                  dAck  <= 1'b0;
                  err   <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each step is checked with an immediate
// assertion against hand-computed values (TIMEOUT set to 4).
module tb_mem_arbiter;
   import beta_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          iReq;
   logic [AW-1:0] iAddr;
   logic          iAck;
   logic [DW-1:0] iRdata;
   logic          dReq;
   logic          dWe;
   logic [AW-1:0] dAddr;
   logic [DW-1:0] dWdata;
   logic          dAck;
   logic [DW-1:0] dRdata;
   logic          memRead;
   logic          memWrite;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWriteData;
   logic          memReadReady;
   logic          memWriteDone;
   logic [DW-1:0] memReadData;
   logic          err;
   arb_state_t    dbgState;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .iReq         (iReq),
      .iAddr        (iAddr),
      .iAck         (iAck),
      .iRdata       (iRdata),
      .dReq         (dReq),
      .dWe          (dWe),
      .dAddr        (dAddr),
      .dWdata       (dWdata),
      .dAck         (dAck),
      .dRdata       (dRdata),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memAddr      (memAddr),
      .memWriteData (memWriteData),
      .memReadReady (memReadReady),
      .memWriteDone (memWriteDone),
      .memReadData  (memReadData),
      .err          (err),
      .dbgState     (dbgState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for an ack pulse; who = {dAck, iAck}, n = negedges waited, zero if no ack arrived.
   task automatic wait_ack(output logic [1:0] who, output int n);
      who = 2'b00;
      n   = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (iAck || dAck) begin
            who = {dAck, iAck};
            n   = k;
            break;
         end
      end
      check("ack_seen", 64'(n != 0), 64'd1);
   endtask

   logic [1:0] who;
   int         n;
   logic [1:0] exp_who [3];

   initial begin
`ifdef MEM_ARBITER_RR_EN
      exp_who[0] = 2'b10; exp_who[1] = 2'b01; exp_who[2] = 2'b10;
`else
      exp_who[0] = 2'b10; exp_who[1] = 2'b10; exp_who[2] = 2'b10;
`endif
      reset = 1'b0; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0;
      dAddr = '0; dWdata = '0; memReadReady = 1'b0; memWriteDone = 1'b0;
      memReadData = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_state", 64'(dbgState), 64'(IDLE));
      check("rst_memrw", {62'd0, memRead, memWrite}, 64'd0);
      check("rst_acks", {61'd0, iAck, dAck, err}, 64'd0);
      check("rst_rdata", {iRdata, dRdata}, 64'd0);
      check("rst_bus", {memAddr, memWriteData}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_noreq", 64'(dbgState), 64'(IDLE));

      // instruction read, two wait cycles
      iReq = 1'b1; iAddr = 32'h100;
      @(negedge clk);
      check("ird_state", 64'(dbgState), 64'(IRD));
      check("ird_rw", {62'd0, memRead, memWrite}, 64'd2);
      check("ird_addr", 64'(memAddr), 64'h100);
      @(negedge clk);
      @(negedge clk);
      memReadReady = 1'b1; memReadData = 32'hDEADBEEF;
      @(negedge clk);
      memReadReady = 1'b0;
      check("ird_resp_rw", {62'd0, memRead, memWrite}, 64'd0);
      check("ird_resp_state", 64'(dbgState), 64'(RESP));
      wait_ack(who, n);
      check("ird_who", 64'(who), 64'd1);
      check("ird_lat", 64'(n), 64'd1);
      check("ird_rdata", 64'(iRdata), 64'hDEADBEEF);
      check("ird_err", 64'(err), 64'd0);
      iReq = 1'b0;
      @(negedge clk);
      check("ird_ack_drop", {62'd0, iAck, dAck}, 64'd0);
      check("ird_idle", 64'(dbgState), 64'(IDLE));

      // simultaneous requests, three back-to-back data reads
      memReadReady = 1'b1; memReadData = 32'h000000AA;
      iReq = 1'b1; iAddr = 32'h104; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h20;
      for (int t = 0; t < 3; t++) begin
         wait_ack(who, n);
         check($sformatf("b2b_who%0d", t), 64'(who), 64'(exp_who[t]));
      end
      dReq = 1'b0;
      wait_ack(who, n);
      check("b2b_tail_who", 64'(who), 64'd1);
      iReq = 1'b0;
      @(negedge clk);

      // minimum-latency data read
      memReadData = 32'hCAFEF00D;
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
      wait_ack(who, n);
      check("drd_who", 64'(who), 64'd2);
      check("drd_minlat", 64'(n), 64'd3);
      check("drd_rdata", 64'(dRdata), 64'hCAFEF00D);
      dReq = 1'b0; memReadReady = 1'b0;
      @(negedge clk);

      // data write, one wait cycle
      dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = 32'h12345678;
      @(negedge clk);
      check("dwr_state", 64'(dbgState), 64'(DWR));
      check("dwr_rw", {62'd0, memRead, memWrite}, 64'd1);
      check("dwr_bus", {memAddr, memWriteData}, {32'h40, 32'h12345678});
      @(negedge clk);
      memWriteDone = 1'b1;
      wait_ack(who, n);
      memWriteDone = 1'b0;
      check("dwr_who", 64'(who), 64'd2);
      check("dwr_lat", 64'(n), 64'd2);
      check("dwr_rdata_kept", 64'(dRdata), 64'hCAFEF00D);
      check("dwr_err", 64'(err), 64'd0);
      dReq = 1'b0; dWe = 1'b0;
      @(negedge clk);

      // read timeout after four wait cycles
      memReadData = 32'h0BADBAD0;
      dReq = 1'b1; dAddr = 32'h200;
      wait_ack(who, n);
      check("tmo_who", 64'(who), 64'd2);
      check("tmo_lat", 64'(n), 64'd6);
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_rdata_kept", 64'(dRdata), 64'hCAFEF00D);
      dReq = 1'b0;
      @(negedge clk);
      check("tmo_err_drop", 64'(err), 64'd0);
      check("tmo_idle", 64'(dbgState), 64'(IDLE));

      // reset during a data read, then a pending fetch is served
      dReq = 1'b1; dAddr = 32'h300;
      @(negedge clk);
      check("arst_drd", 64'(dbgState), 64'(DRD));
      check("arst_rd_hi", 64'(memRead), 64'd1);
      iReq = 1'b1; iAddr = 32'h500;
      #2 reset = 1'b0;
      #1;
      check("arst_rd_lo", 64'(memRead), 64'd0);
      check("arst_idle", 64'(dbgState), 64'(IDLE));
      check("arst_rdata", {iRdata, dRdata}, 64'd0);
      dReq = 1'b0;
      @(negedge clk);
      check("arst_noack", {61'd0, iAck, dAck, err}, 64'd0);
      reset = 1'b1;
      memReadReady = 1'b1; memReadData = 32'h5A5A5A5A;
      wait_ack(who, n);
      check("arst_who", 64'(who), 64'd1);
      check("arst_lat", 64'(n), 64'd3);
      check("arst_irdata", 64'(iRdata), 64'h5A5A5A5A);
      iReq = 1'b0; memReadReady = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
